// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port.
// A winning IDLE edge registers gnt/load/wdata directly, so every output is a flop.
module rf_write_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter bit PROTECT_R0 = 1'b1,
  localparam int NREG      = 1 << ADDR_W
) (
  input  logic              C,
  input  logic              nR,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [NREG-1:0]   load,
  output logic [DATA_W-1:0] wdata,
  output logic              busy
);

  typedef enum logic {IDLE, WR} state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                busy_q, busy_d;
  logic [NREG-1:0]     load_q, load_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                win;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   data_sel;
  logic [NREG-1:0]     dec;

  // Single requester wins outright; rr_q only breaks ties.
  assign win      = (req0 && req1) ? rr_q : req1;
  assign addr_sel = win ? addr1 : addr0;
  assign data_sel = win ? data1 : data0;

  genvar i;
  generate
    for (i = 0; i < NREG; i++) begin : g_dec
      if (i == 0 && PROTECT_R0) begin : g_r0
        assign dec[i] = 1'b0;
      end else begin : g_rn
        assign dec[i] = (addr_sel == ADDR_W'(i));
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    busy_d  = 1'b0;
    load_d  = '0;
    wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = WR;
          rr_d    = ~win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          busy_d  = 1'b1;
          load_d  = dec;
          wdata_d = data_sel;
        end
      end
      WR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      load_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign busy  = busy_q;
  assign load  = load_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized requesters
// checked every cycle against a transaction-level model.
module tb_rf_write_arbiter;

  logic        C = 1'b0;
  logic        nR;
  logic        req0, req1;
  logic [4:0]  addr0, addr1;
  logic [31:0] data0, data1;
  logic        gnt0, gnt1, busy;
  logic [31:0] load, wdata;

  int n_cmp = 0;
  int n_err = 0;
  bit done  = 1'b0;

  rf_write_arbiter #(.ADDR_W(5), .DATA_W(32), .PROTECT_R0(1'b1)) dut (
    .C(C), .nR(nR),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .load(load), .wdata(wdata), .busy(busy)
  );

  always #5 C = ~C;

  // Model: one write occupies the port for the cycle after its winning edge.
  logic        m_wr = 1'b0;
  logic        m_rr = 1'b0;
  logic        e_g0 = 1'b0, e_g1 = 1'b0;
  logic [31:0] e_load = '0, e_wd = '0;

  function automatic logic [31:0] lmask(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'd1 << a);
  endfunction

  wire m_win = (req0 && req1) ? m_rr : req1;

  always @(posedge C or negedge nR) begin
    if (!nR) begin
      m_wr <= 1'b0; m_rr <= 1'b0; e_g0 <= 1'b0; e_g1 <= 1'b0;
      e_load <= '0; e_wd <= '0;
    end else if (!m_wr && (req0 || req1)) begin
      m_wr   <= 1'b1;
      m_rr   <= !m_win;
      e_g0   <= !m_win;
      e_g1   <= m_win;
      e_load <= lmask(m_win ? addr1 : addr0);
      e_wd   <= m_win ? data1 : data0;
    end else begin
      m_wr <= 1'b0; e_g0 <= 1'b0; e_g1 <= 1'b0;
      e_load <= '0; e_wd <= '0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge C) begin
    if (!done) begin
      chk("m_gnt0", gnt0, e_g0);
      chk("m_gnt1", gnt1, e_g1);
      chk("m_busy", busy, m_wr);
      chk("m_load", load, e_load);
      if (m_wr) chk("m_wdata", wdata, e_wd);
    end
  end

  task automatic tick();
    @(negedge C);
  endtask

  initial begin
    nR = 1'b0; req0 = 1'b1; req1 = 1'b0;
    addr0 = 5'd5; addr1 = 5'd0; data0 = 32'h55; data1 = '0;

    // reset holds everything quiet even with a request pending
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
      chk("rst_busy", busy, 0); chk("rst_load", load, 0);
      chk("rst_wdata", wdata, 0);
    end

    // single request
    nR = 1'b1; req0 = 1'b1; addr0 = 5'd5; data0 = 32'hDEAD_BEEF;
    tick();
    chk("single_gnt0", gnt0, 1); chk("single_busy", busy, 1);
    chk("single_load", load, 32'h0000_0020); chk("single_wdata", wdata, 32'hDEAD_BEEF);
    req0 = 1'b0;
    tick();
    chk("single_load_off", load, 0); chk("single_busy_off", busy, 0);

    nR = 1'b0; tick(); nR = 1'b1;

    // contention alternates starting with requester 0
    req0 = 1'b1; req1 = 1'b1; addr0 = 5'd3; addr1 = 5'd7;
    data0 = 32'hA0A0_0003; data1 = 32'hB0B0_0007;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k % 2 == 0) begin
        chk("cont_gnt0", gnt0, ((k / 2) % 2) == 0);
        chk("cont_gnt1", gnt1, ((k / 2) % 2) == 1);
        chk("cont_load", load, ((k / 2) % 2) ? 32'h80 : 32'h8);
      end else begin
        chk("cont_idle", busy, 0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // write to r0 completes without a load
    req1 = 1'b1; addr1 = 5'd0; data1 = 32'h1234;
    tick();
    chk("prot_gnt1", gnt1, 1); chk("prot_busy", busy, 1); chk("prot_load", load, 0);
    req1 = 1'b0;
    tick();

    // reset during WR abandons the write
    req1 = 1'b1; addr1 = 5'd9; data1 = 32'h9999;
    tick();
    chk("mid_busy", busy, 1); chk("mid_load", load, 32'h200);
    #1 nR = 1'b0;
    #1;
    chk("mid_load0", load, 0); chk("mid_gnt1", gnt1, 0); chk("mid_busy0", busy, 0);
    tick();
    nR = 1'b1; req0 = 1'b1; addr0 = 5'd2; data0 = 32'h2222;
    tick();
    chk("post_gnt0", gnt0, 1); chk("post_gnt1", gnt1, 0); chk("post_load", load, 32'h4);
    req0 = 1'b0;
    tick();
    chk("post_idle_gnt1", gnt1, 0);
    tick();
    chk("post_gnt1_late", gnt1, 1); chk("post_load1", load, 32'h200);
    req1 = 1'b0;
    tick();

    // request arriving during WR waits for the next IDLE edge
    req0 = 1'b1; addr0 = 5'd1; data0 = 32'h1111;
    tick();
    chk("ign_gnt0", gnt0, 1); chk("ign_gnt1_same", gnt1, 0);
    req0 = 1'b0; req1 = 1'b1; addr1 = 5'd4; data1 = 32'h4444;
    tick();
    chk("ign_gnt1_gap", gnt1, 0);
    tick();
    chk("ign_gnt1", gnt1, 1); chk("ign_load", load, 32'h10); chk("ign_wdata", wdata, 32'h4444);
    req1 = 1'b0;
    tick();

    // randomized requesters obeying the hold-until-grant handshake
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!req0 || gnt0) begin
        req0  = ($urandom_range(0, 2) != 0);
        addr0 = 5'($urandom);
        data0 = $urandom;
      end
      if (!req1 || gnt1) begin
        req1  = ($urandom_range(0, 2) != 0);
        addr1 = 5'($urandom);
        data1 = $urandom;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 nR = 1'b0;
        tick();
        #2 nR = 1'b1;
      end
    end

    tick();
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
